// File: rtl/mii_rx_fcs_checker_if.sv
// MII receive pins plus the framed byte stream and status toward the MAC RX FIFO.
interface mii_rx_fcs_checker_if;
    logic        i_rx_dv;
    logic        i_rx_er;
    logic [3:0]  i_rxd;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_sof;
    logic        o_eof;
    logic        o_fcs_ok;
    logic [4:0]  o_err;
    logic [15:0] o_good_cnt;
    logic [15:0] o_bad_cnt;

    modport master (
        output i_rx_dv, i_rx_er, i_rxd,
        input  o_data, o_valid, o_sof, o_eof, o_fcs_ok, o_err, o_good_cnt, o_bad_cnt
    );

    modport slave (
        input  i_rx_dv, i_rx_er, i_rxd,
        output o_data, o_valid, o_sof, o_eof, o_fcs_ok, o_err, o_good_cnt, o_bad_cnt
    );
endinterface

// File: rtl/mii_rx_fcs_checker.sv
// MII RX deframer: preamble/SFD search, nibble-to-byte assembly, FCS strip,
// CRC-32 residue check, per-frame status and saturating good/bad counters.
module mii_rx_fcs_checker #(
    parameter int P_MIN_FRAME = 64,
    parameter int P_MAX_FRAME = 1518
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    mii_rx_fcs_checker_if.slave  bus
);

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [10:0] MIN_LEN     = 11'(P_MIN_FRAME);
    localparam logic [10:0] MAX_LEN     = 11'(P_MAX_FRAME);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    state_t      state;
    logic [31:0] crc;
    logic [10:0] len;
    logic        phase;
    logic [3:0]  nib_lo;
    logic [7:0]  fbuf [0:4];
    logic [2:0]  fcnt;
    logic        sof_done;
    logic        er_flag;

    logic [7:0]  byte_c;
    logic        fcs_ok_c;
    logic [4:0]  err_c;

    // Input byte is consumed LSB first, which is the bit reversal the MSB-first register needs.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i])
                r = {r[30:0], 1'b0} ^ CRC_POLY;
            else
                r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    function automatic logic [10:0] sat_inc11(input logic [10:0] x);
        return (x == 11'h7FF) ? x : x + 11'd1;
    endfunction

    always_comb begin
        byte_c   = {bus.i_rxd, nib_lo};
        fcs_ok_c = (crc == CRC_RESIDUE);
        err_c    = {phase,
                    (len > MAX_LEN),
                    (len < MIN_LEN) || (fcnt != 3'd5),
                    er_flag | bus.i_rx_er,
                    !fcs_ok_c};
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            crc            <= '0;
            len            <= '0;
            phase          <= 1'b0;
            nib_lo         <= '0;
            fcnt           <= '0;
            sof_done       <= 1'b0;
            er_flag        <= 1'b0;
            for (int i = 0; i < 5; i++) fbuf[i] <= '0;
            bus.o_data     <= '0;
            bus.o_valid    <= 1'b0;
            bus.o_sof      <= 1'b0;
            bus.o_eof      <= 1'b0;
            bus.o_fcs_ok   <= 1'b0;
            bus.o_err      <= '0;
            bus.o_good_cnt <= '0;
            bus.o_bad_cnt  <= '0;
        end else begin
            bus.o_valid  <= 1'b0;
            bus.o_sof    <= 1'b0;
            bus.o_eof    <= 1'b0;
            bus.o_fcs_ok <= 1'b0;
            bus.o_err    <= '0;

            case (state)
                IDLE: begin
                    if (bus.i_rx_dv)
                        state <= (bus.i_rxd == 4'h5) ? PREAMBLE : DROP;
                end

                PREAMBLE: begin
                    if (!bus.i_rx_dv) begin
                        state <= IDLE;
                    end else if (bus.i_rxd == 4'hD) begin
                        state    <= DATA;
                        crc      <= 32'hFFFF_FFFF;
                        len      <= '0;
                        phase    <= 1'b0;
                        fcnt     <= '0;
                        sof_done <= 1'b0;
                        er_flag  <= 1'b0;
                    end else if (bus.i_rxd != 4'h5) begin
                        state         <= DROP;
                        bus.o_bad_cnt <= sat_inc16(bus.o_bad_cnt);
                    end
                end

                DATA: begin
                    if (bus.i_rx_dv) begin
                        if (bus.i_rx_er) er_flag <= 1'b1;
                        if (!phase) begin
                            nib_lo <= bus.i_rxd;
                            phase  <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            crc   <= crc_byte(crc, byte_c);
                            len   <= sat_inc11(len);
                            // Five-byte delay line keeps the FCS (plus one) back from the output.
                            if (fcnt == 3'd5) begin
                                bus.o_data  <= fbuf[0];
                                bus.o_valid <= 1'b1;
                                bus.o_sof   <= !sof_done;
                                sof_done    <= 1'b1;
                                for (int i = 0; i < 4; i++) fbuf[i] <= fbuf[i+1];
                                fbuf[4] <= byte_c;
                            end else begin
                                fbuf[fcnt] <= byte_c;
                                fcnt       <= fcnt + 3'd1;
                            end
                        end
                    end else begin
                        state        <= IDLE;
                        bus.o_data   <= (fcnt == 3'd5) ? fbuf[0] : 8'h00;
                        bus.o_valid  <= 1'b1;
                        bus.o_sof    <= !sof_done;
                        bus.o_eof    <= 1'b1;
                        bus.o_fcs_ok <= fcs_ok_c;
                        bus.o_err    <= err_c;
                        if (err_c == 5'd0)
                            bus.o_good_cnt <= sat_inc16(bus.o_good_cnt);
                        else
                            bus.o_bad_cnt  <= sat_inc16(bus.o_bad_cnt);
                    end
                end

                DROP: begin
                    if (!bus.i_rx_dv) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
